// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory response block:
// FSM state encoding, wait-state counter width and legal byte-enable patterns.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int CNT_W = 3;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // A store is aligned when its byte-enable pattern is legal and its lowest lane matches addr[1:0].
    function automatic logic be_aligned(input logic [3:0] be, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0, BE_H0, BE_W: ok = (lo == 2'd0);
            BE_B1:              ok = (lo == 2'd1);
            BE_B2, BE_H1:       ok = (lo == 2'd2);
            BE_B3:              ok = (lo == 2'd3);
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Single-port byte-lane RAM with per-lane write enables and a registered read port.
// Storage is never reset; only the read register clears on rst.
module dmem_ram_bank #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem_r [0:DEPTH-1];
    logic [31:0] rdata_r;

    // Byte-lane writes into the storage array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register: loads only on a read so the last read word is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_resp.sv
// MEM-stage data memory with IDLE/WAIT/RESP handshake, programmable wait states and stall output.
// Define DMEM_MISALIGN_CHECK_EN to suppress misaligned stores and flag them on err_o.
import dmem_pkg::*;

module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WS_CNT   = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    dmem_state_e      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [AW+1:0]    addr_r;
    logic [3:0]       we_r;
    logic [31:0]      wdata_r;
    logic             ack_r, err_r;
    logic             access_s, use_in_s;
    logic [AW+1:0]    acc_addr_s;
    logic [3:0]       acc_we_s;
    logic [31:0]      acc_wdata_s;
    logic             misaligned_s, wr_en_s, rd_en_s;
    logic             unused_addr_s;

    assign unused_addr_s = ^addr_i[31:AW+2];

    // Next-state and counter logic; the access fires on the edge that leaves WAIT (or IDLE when WAIT_STATES=0).
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        access_s = 1'b0;
        use_in_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_i) begin
                    cnt_s = WS_CNT;
                    if (WS_CNT == CNT_ZERO) begin
                        state_s  = ST_RESP;
                        access_s = 1'b1;
                        use_in_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // One WAIT cycle per wait state: access when the decremented count reaches 0.
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s  = ST_RESP;
                    access_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Access operands: live inputs for a zero-wait access, latched request otherwise.
    always_comb begin
        if (use_in_s) begin
            acc_addr_s  = addr_i[AW+1:0];
            acc_we_s    = we_i;
            acc_wdata_s = wdata_i;
        end else begin
            acc_addr_s  = addr_r;
            acc_we_s    = we_r;
            acc_wdata_s = wdata_r;
        end
    end

    assign misaligned_s = CHK_EN & (acc_we_s != 4'b0000) & ~be_aligned(acc_we_s, acc_addr_s[1:0]);
    assign wr_en_s      = access_s & ~rst_n & (acc_we_s != 4'b0000) & ~misaligned_s;
    assign rd_en_s      = access_s & ~rst_n & (acc_we_s == 4'b0000);

    // FSM, counter and response pulse registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ack_r   <= access_s;
            err_r   <= access_s & misaligned_s;
        end
    end

    // Request capture on acceptance so later input changes cannot disturb the access.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            addr_r  <= {(AW+2){1'b0}};
            we_r    <= 4'b0000;
            wdata_r <= 32'h0000_0000;
        end else if (state_r == ST_IDLE && req_i) begin
            addr_r  <= addr_i[AW+1:0];
            we_r    <= we_i;
            wdata_r <= wdata_i;
        end
    end

    dmem_ram_bank #(
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst_n),
        .wr_en (wr_en_s),
        .rd_en (rd_en_s),
        .be    (acc_we_s),
        .addr  (acc_addr_s[AW+1:2]),
        .wdata (acc_wdata_s),
        .rdata (rdata_o)
    );

    assign ack_o   = ack_r;
    assign err_o   = err_r;
    assign stall_o = ((state_r == ST_IDLE) && req_i) || (state_r == ST_WAIT);

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance with WAIT_STATES=1 and one with WAIT_STATES=0.
module tb_data_mem_resp;

    logic        clk;
    logic        rst1, req1, ack1, stall1, err1;
    logic [3:0]  we1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        rst0, req0, ack0, stall0, err0;
    logic [3:0]  we0;
    logic [31:0] addr0, wdata0, rdata0;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst1), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1), .stall_o(stall1), .err_o(err1)
    );

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst0), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wdata_i(wdata0), .rdata_o(rdata0), .ack_o(ack0), .stall_o(stall0), .err_o(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one access; inputs are scrambled after acceptance, latency counts cycles after the accept cycle.
    task automatic acc(input bit w, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                       input bit keep, output int lat, output int stl, output logic [31:0] rd,
                       output logic er, output logic stall_resp);
        @(negedge clk);
        if (w) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
        else   begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
        #1;
        stl = ((w ? stall1 : stall0) === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        if (w) begin we1 = ~we; addr1 = addr ^ 32'h0000_0008; wdata1 = ~wd; end
        else   begin we0 = ~we; addr0 = addr ^ 32'h0000_0008; wdata0 = ~wd; end
        lat = 0; rd = 32'hxxxx_xxxx; er = 1'bx; stall_resp = 1'bx;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            lat++;
            if ((w ? ack1 : ack0) === 1'b1) begin
                rd = w ? rdata1 : rdata0;
                er = w ? err1 : err0;
                stall_resp = w ? stall1 : stall0;
                break;
            end
            if ((w ? stall1 : stall0) === 1'b1) stl++;
        end
        if (!keep) begin
            if (w) begin req1 = 1'b0; we1 = 4'b0000; end
            else   begin req0 = 1'b0; we0 = 4'b0000; end
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst0 = 1'b1;
        req1 = 1'b0; we1 = 4'b0000; addr1 = 32'h0; wdata1 = 32'h0;
        req0 = 1'b0; we0 = 4'b0000; addr0 = 32'h0; wdata0 = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ack1 !== 1'b0)   begin n_bad++; $display("FAIL rst_ack1: got %b want 0", ack1); end
        n_cmp++; if (err1 !== 1'b0)   begin n_bad++; $display("FAIL rst_err1: got %b want 0", err1); end
        n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL rst_rdata1: got %h want 0", rdata1); end
        n_cmp++; if (stall1 !== 1'b0) begin n_bad++; $display("FAIL rst_stall_idle: got %b want 0", stall1); end
        n_cmp++; if (ack0 !== 1'b0)   begin n_bad++; $display("FAIL rst_ack0: got %b want 0", ack0); end
        req1 = 1'b1;
        #1;
        n_cmp++; if (stall1 !== 1'b1) begin n_bad++; $display("FAIL rst_stall_req: got %b want 1", stall1); end
        req1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b0; rst0 = 1'b0;
    endtask

    task automatic test_write_read();
        int lat, stl; logic [31:0] rd; logic er, sr;
        acc(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_cmp++; if (stl !== 2) begin n_bad++; $display("FAIL wr_stall_cycles: got %0d want 2", stl); end
        n_cmp++; if (sr !== 1'b0) begin n_bad++; $display("FAIL wr_stall_resp: got %b want 0", sr); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", er); end
        acc(1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
        n_cmp++; if (stl !== 2) begin n_bad++; $display("FAIL rd_stall_cycles: got %0d want 2", stl); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        @(negedge clk);
        n_cmp++; if (ack1 !== 1'b0) begin n_bad++; $display("FAIL ack_one_cycle: got %b want 0", ack1); end
        n_cmp++; if (rdata1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdata_hold: got %h want deadbeef", rdata1); end
    endtask

    task automatic test_byte_lane();
        int lat, stl; logic [31:0] rd; logic er, sr;
        acc(1'b1, 4'b0100, 32'h12, 32'h00AB0000, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_keeps_rdata: got %h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lane_err: got %b want 0", er); end
        acc(1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (rd !== 32'hDEABBEEF) begin n_bad++; $display("FAIL lane_merge: got %h want deabbeef", rd); end
    endtask

    task automatic test_wrap();
        int lat, stl; logic [31:0] rd; logic er, sr;
        acc(1'b1, 4'b1111, 32'h1000, 32'hCAFEF00D, 1'b0, lat, stl, rd, er, sr);
        acc(1'b1, 4'b0000, 32'h0000, 32'h0, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL addr_wrap: got %h want cafef00d", rd); end
    endtask

    task automatic test_reset_mid_wait();
        int lat, stl; logic [31:0] rd; logic er, sr; bit seen;
        acc(1'b1, 4'b1111, 32'h20, 32'hA5A5A5A5, 1'b0, lat, stl, rd, er, sr);
        @(negedge clk);
        req1 = 1'b1; we1 = 4'b1111; addr1 = 32'h20; wdata1 = 32'h55555555;
        @(posedge clk);
        #1;
        req1 = 1'b0; we1 = 4'b0000;
        n_cmp++; if (stall1 !== 1'b1) begin n_bad++; $display("FAIL in_wait_stall: got %b want 1", stall1); end
        #2 rst1 = 1'b1;
        #1;
        n_cmp++; if (stall1 !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got stall %b want 0", stall1); end
        n_cmp++; if (ack1 !== 1'b0) begin n_bad++; $display("FAIL abort_ack: got %b want 0", ack1); end
        n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL abort_rdata: got %h want 0", rdata1); end
        rst1 = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack1 === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_ack: got %b want 0", seen); end
        acc(1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL abort_no_write: got %h want a5a5a5a5", rd); end
    endtask

    task automatic test_misalign();
        int lat, stl; logic [31:0] rd; logic er, sr; logic [31:0] exp_word; logic exp_err;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_word = 32'hA5A5A5A5; exp_err = 1'b1;
`else
        exp_word = 32'h12345678; exp_err = 1'b0;
`endif
        acc(1'b1, 4'b1111, 32'h22, 32'h12345678, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (er !== exp_err) begin n_bad++; $display("FAIL misalign_err: got %b want %b", er, exp_err); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL misalign_latency: got %0d want 2", lat); end
        @(negedge clk);
        n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b want 0", err1); end
        acc(1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (rd !== exp_word) begin n_bad++; $display("FAIL misalign_mem: got %h want %h", rd, exp_word); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b want 0", er); end
    endtask

    task automatic test_back_to_back();
        int lat, stl; logic [31:0] rd; logic er, sr;
        acc(1'b0, 4'b1111, 32'h0, 32'h11112222, 1'b0, lat, stl, rd, er, sr);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ws0_wr_latency: got %0d want 1", lat); end
        acc(1'b0, 4'b1111, 32'h4, 32'h33334444, 1'b0, lat, stl, rd, er, sr);
        acc(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, lat, stl, rd, er, sr);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ws0_rd_latency: got %0d want 1", lat); end
        n_cmp++; if (stl !== 1) begin n_bad++; $display("FAIL ws0_stall_cycles: got %0d want 1", stl); end
        n_cmp++; if (rd !== 32'h11112222) begin n_bad++; $display("FAIL ws0_rd0: got %h want 11112222", rd); end
        addr0 = 32'h4; we0 = 4'b0000; wdata0 = 32'h0;
        @(negedge clk);
        n_cmp++; if (ack0 !== 1'b0) begin n_bad++; $display("FAIL no_accept_in_resp: got ack %b want 0", ack0); end
        n_cmp++; if (stall0 !== 1'b1) begin n_bad++; $display("FAIL idle_req_stall: got %b want 1", stall0); end
        @(negedge clk);
        n_cmp++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL ws0_second_ack: got %b want 1", ack0); end
        n_cmp++; if (rdata0 !== 32'h33334444) begin n_bad++; $display("FAIL ws0_rd4: got %h want 33334444", rdata0); end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lane();
        test_wrap();
        test_reset_mid_wait();
        test_misalign();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words; it must be a power of two.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, meaning the number of extra cycles (0..7) between request acceptance and the access.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-high (asserted = 1).
REQ-005 The block SHALL have port req_i  input  1  the MEM-stage access request; it is held high until ack_o.
REQ-006 The block SHALL have port we_i  input  4  byte write enables; 4'b0000 means a read.
REQ-007 The block SHALL have port addr_i  input  32  byte address.
REQ-008 The block SHALL have port wdata_i  input  32  store data, lane-aligned.
REQ-009 The block SHALL have port rdata_o  output  32  the full word read from the memory.
REQ-010 The block SHALL have port ack_o  output  1  a one-cycle completion pulse.
REQ-011 The block SHALL have port stall_o  output  1  freezes the PC and IF-ID register.
REQ-012 The block SHALL have port err_o  output  1  a misaligned-store flag (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE with req_i=1, the block SHALL latch addr_i, we_i and wdata_i and load the counter with WAIT_STATES.
  - Next state is WAIT, or RESP if WAIT_STATES=0.
REQ-015 In WAIT the counter SHALL decrement each cycle, and at count 0 the access SHALL be performed and the state SHALL go to RESP.
REQ-016 With WAIT_STATES=0 the access SHALL be performed on the accept edge.
REQ-017 Word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-018 Reads SHALL ignore addr[1:0] and return the whole word; byte/halfword extraction belongs to the datapath.
REQ-019 A write SHALL update only the byte lanes whose we bit is 1; other lanes SHALL be unchanged.
REQ-020 In RESP, ack_o SHALL be 1 for exactly one cycle and rdata_o SHALL be valid.
  - rdata_o holds its value until the next read completes.
  - For writes, rdata_o is unchanged.
REQ-021 Latency from the accept edge to ack_o high SHALL be WAIT_STATES+1 cycles.
REQ-022 req_i SHALL be ignored in RESP, since it is still the completing request; RESP always returns to IDLE.
REQ-023 The next access SHALL be accepted no earlier than the IDLE cycle following RESP.
REQ-024 stall_o SHALL be combinational: (IDLE and req_i) or WAIT; it is 0 in RESP so the pipeline advances with ack_o.
REQ-025 Input changes after acceptance SHALL have no effect on the access in flight.

Reset
REQ-026 On rst_n=1, regardless of clk, the state SHALL become IDLE.
  - Counter = 0; ack_o = 0; err_o = 0; rdata_o = 32'h0; stall_o follows REQ-024.
REQ-027 Reset during WAIT SHALL abort the access, and no write SHALL be committed.
REQ-028 Memory contents SHALL NOT be reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_CHECK_EN SHALL control the misaligned-store check.
  - Defined: a write is misaligned unless we_i is one of 0001, 0010, 0100, 1000, 0011, 1100, 1111, and the lowest set bit index equals addr[1:0].
  - Defined, misaligned: the write is suppressed, and err_o pulses with ack_o; latency is unchanged.
  - Not defined: err_o is tied 0, and every write is performed as enabled.

Structure
REQ-030 A shared package dmem_pkg SHALL hold the FSM state enum, the WAIT_STATES counter width (3), and the legal byte-enable constants.
REQ-031 A sub-module dmem_ram_bank SHALL implement the byte-lane synchronous RAM: one port, per-lane write enables, registered read.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
  - WAIT_STATES=1: write we=1111 addr=0x10 data=0xDEADBEEF, then read 0x10 -> ack 2 cycles after each accept; rdata_o=0xDEADBEEF; stall_o high for 2 cycles per access.
  - Write we=0100 addr=0x12 data=0x00AB0000 over 0xDEADBEEF, then read 0x10 -> rdata_o=0xDEABBEEF.
  - WAIT_STATES=0: back-to-back reads of 0x0 and 0x4 with req_i held -> each acked 1 cycle after accept; no access is issued in RESP.
  - DEPTH_WORDS=1024: write 0x1000 and read 0x0000 -> same word is returned (wrap).
  - rst_n pulsed mid-WAIT during write of 0x55555555 to 0x20 -> state IDLE, ack_o 0, word at 0x20 unchanged.
  - DMEM_MISALIGN_CHECK_EN defined: write we=1111 addr=0x22 -> err_o=1 with ack_o, memory unchanged; without the macro, err_o=0 and the write is performed.
